// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer turning one CPU load/store into 1 or 8 byte beats on a
// valid/ready byte-wide memory port, stalling the pipeline until it completes.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BYTES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [3:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned CNT_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned SIZE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              write_q;
    logic              byte_q;
    logic              err_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  count;
    logic              legal;
    logic              last_beat;
    logic              accept;
    logic              beat;

    assign legal     = (req_size == SIZE_W'(MAX_BYTES)) || (req_size == SIZE_W'(1));
    assign last_beat = byte_q || (count == CNT_W'(MAX_BYTES - 1));
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and port decode; beat signals are held stable by the latched copy.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        accept    = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = legal ? XFER : DONE;
                end
            end
            XFER: begin
                stall     = 1'b1;
                mem_valid = 1'b1;
                mem_write = write_q;
                mem_addr  = base_q + ADDR_W'(count);
                mem_wdata = wdata_q[{count, 3'b000} +: 8];
                if (mem_ready) begin
                    beat = 1'b1;
                    if (last_beat) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, beat counter and load assembly buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            count   <= '0;
        end else if (accept) begin
            write_q <= req_write;
            byte_q  <= (req_size == SIZE_W'(1));
            err_q   <= !legal;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            count   <= '0;
        end else if (beat) begin
            if (!write_q) begin
                rdata_q[{count, 3'b000} +: 8] <= mem_rdata;
            end
            if (!last_beat) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a byte memory responder with
// programmable wait states, expected beats/responses queued at issue time.
module tb_mem_access_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_valid;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    mem_access_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; logic wr; logic [7:0] wdata; } beat_t;
    typedef struct { logic [63:0] addr; logic wr; logic [7:0] wdata; logic taken; } obs_beat_t;
    typedef struct { logic err; logic [63:0] rdata; int lat; } rsp_t;
    typedef struct { logic err; logic [63:0] rdata; int lat; logic stall; int stall_run; } obs_rsp_t;

    beat_t     exp_beat_q[$];
    obs_beat_t obs_beat_q[$];
    rsp_t      exp_rsp_q[$];
    obs_rsp_t  obs_rsp_q[$];

    logic [7:0] mem     [logic [63:0]];
    logic [7:0] ref_mem [logic [63:0]];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int stall_run = 0;
    int held = 0;
    int hold_cfg = 0;
    bit prev_valid = 0;
    bit accepted_now = 0;

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // One clock: observe and respond at the falling edge, return just after the rising edge.
    task automatic step();
        obs_beat_t o;
        obs_rsp_t  r;
        @(negedge clk);
        if (!reset_n) begin
            mem_ready  = 1'b1;
            mem_rdata  = 8'h00;
            held       = 0;
            prev_valid = 0;
            stall_run  = 0;
        end else begin
            if (req_valid && req_ready) begin
                accept_cyc   = cyc;
                accepted_now = 1;
            end
            if (rsp_valid) begin
                r.err       = rsp_err;
                r.rdata     = rsp_rdata;
                r.lat       = cyc - accept_cyc;
                r.stall     = stall;
                r.stall_run = stall_run;
                obs_rsp_q.push_back(r);
            end
            stall_run = stall ? stall_run + 1 : 0;
            if (mem_valid) begin
                if (!prev_valid) held = 0;
                o.addr  = mem_addr;
                o.wr    = mem_write;
                o.wdata = mem_wdata;
                o.taken = (held >= hold_cfg);
                if (o.taken) begin
                    mem_ready = 1'b1;
                    if (mem_write) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    held++;
                end
                obs_beat_q.push_back(o);
            end else begin
                mem_ready = 1'b1;
                mem_rdata = 8'h5A;
            end
            prev_valid = mem_valid;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic wr, input logic [3:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input int hold);
        beat_t       b;
        rsp_t        r;
        int          n;
        logic [63:0] a;
        bit          got;
        n       = (size == 4'd8) ? 8 : (size == 4'd1) ? 1 : 0;
        r.err   = (n == 0);
        r.rdata = '0;
        r.lat   = (n == 0) ? 1 : n + 1 + hold;
        for (int i = 0; i < n; i++) begin
            a       = addr + 64'(i);
            b.addr  = a;
            b.wr    = wr;
            b.wdata = wdata[8*i +: 8];
            exp_beat_q.push_back(b);
            if (wr) ref_mem[a] = wdata[8*i +: 8];
            else r.rdata[8*i +: 8] = ref_rd(a);
        end
        exp_rsp_q.push_back(r);
        hold_cfg  = hold;
        req_valid = 1'b1;
        req_write = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            accepted_now = 0;
            step();
            got = accepted_now;
        end
        // Scramble the request lines; the sequencer must work from its latched copy.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 4'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n_cmp++;
        if (!got) begin
            n_mis++;
            $display("FAIL accept_timeout addr=%h got req_ready=%b want accept", addr, req_ready);
        end
    endtask

    // Run until every queued response is observed, then pop and compare.
    task automatic drain(input string tag);
        obs_beat_t o;
        beat_t     e;
        obs_rsp_t  orr;
        rsp_t      er;
        int        k;
        k = 0;
        while (obs_rsp_q.size() < exp_rsp_q.size() && k < 200) begin
            step();
            k++;
        end
        while (obs_beat_q.size() > 0) begin
            o = obs_beat_q.pop_front();
            n_cmp++;
            if (exp_beat_q.size() == 0) begin
                n_mis++;
                $display("FAIL %s extra_beat got addr=%h wr=%b want none", tag, o.addr, o.wr);
            end else begin
                e = exp_beat_q[0];
                if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.wdata !== e.wdata)) begin
                    n_mis++;
                    $display("FAIL %s beat got addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                             tag, o.addr, o.wr, o.wdata, e.addr, e.wr, e.wdata);
                end
                if (o.taken) void'(exp_beat_q.pop_front());
            end
        end
        n_cmp++;
        if (exp_beat_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s missing_beats got %0d left want 0", tag, exp_beat_q.size());
            exp_beat_q.delete();
        end
        while (obs_rsp_q.size() > 0) begin
            orr = obs_rsp_q.pop_front();
            n_cmp++;
            if (exp_rsp_q.size() == 0) begin
                n_mis++;
                $display("FAIL %s unexpected_rsp got err=%b rdata=%h want none", tag, orr.err, orr.rdata);
            end else begin
                er = exp_rsp_q.pop_front();
                if (orr.err !== er.err || orr.rdata !== er.rdata) begin
                    n_mis++;
                    $display("FAIL %s rsp got err=%b rdata=%h want err=%b rdata=%h",
                             tag, orr.err, orr.rdata, er.err, er.rdata);
                end
                n_cmp++;
                if (orr.lat != er.lat) begin
                    n_mis++;
                    $display("FAIL %s latency got %0d want %0d", tag, orr.lat, er.lat);
                end
                n_cmp++;
                if (orr.stall !== 1'b0 || orr.stall_run != er.lat) begin
                    n_mis++;
                    $display("FAIL %s stall got done_stall=%b run=%0d want 0 run=%0d",
                             tag, orr.stall, orr.stall_run, er.lat);
                end
            end
        end
        n_cmp++;
        if (exp_rsp_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s missing_rsp got %0d pending want 0", tag, exp_rsp_q.size());
            exp_rsp_q.delete();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({mem_valid, mem_write, rsp_valid, rsp_err, stall, req_ready} !== 6'b000001) begin
            n_mis++;
            $display("FAIL reset_ctrl got %b want 000001",
                     {mem_valid, mem_write, rsp_valid, rsp_err, stall, req_ready});
        end
        n_cmp++;
        if (mem_addr !== 64'h0 || mem_wdata !== 8'h0 || rsp_rdata !== 64'h0) begin
            n_mis++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata);
        end
        reset_n = 1'b1;
        step();
        step();
        n_cmp++;
        if ({mem_valid, stall, rsp_valid, req_ready} !== 4'b0001) begin
            n_mis++;
            $display("FAIL idle_ctrl got %b want 0001", {mem_valid, stall, rsp_valid, req_ready});
        end
    endtask

    task automatic test_load8();
        for (int i = 0; i < 8; i++) begin
            mem[64'h100 + 64'(i)]     = 8'(i + 1);
            ref_mem[64'h100 + 64'(i)] = 8'(i + 1);
        end
        issue(1'b0, 4'b1000, 64'h100, 64'hDEAD_BEEF_0BAD_F00D, 0);
        drain("load8");
        repeat (3) step();
        n_cmp++;
        if (rsp_rdata !== 64'h0807060504030201) begin
            n_mis++;
            $display("FAIL load8_hold got %h want 0807060504030201", rsp_rdata);
        end
    endtask

    task automatic test_store8();
        logic [63:0] got;
        issue(1'b1, 4'b1000, 64'h20, 64'h1122334455667788, 0);
        drain("store8");
        for (int i = 0; i < 8; i++) got[8*i +: 8] = mem_rd(64'h20 + 64'(i));
        n_cmp++;
        if (got !== 64'h1122334455667788 || rsp_rdata !== 64'h0) begin
            n_mis++;
            $display("FAIL store8_mem got mem=%h rdata=%h want 1122334455667788 rdata=0", got, rsp_rdata);
        end
    endtask

    task automatic test_byte_wait();
        mem[64'h7]     = 8'hAB;
        ref_mem[64'h7] = 8'hAB;
        issue(1'b0, 4'b0001, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        drain("byte_wait");
        n_cmp++;
        if (rsp_rdata !== 64'h00000000000000AB) begin
            n_mis++;
            $display("FAIL byte_wait_rdata got %h want 00000000000000ab", rsp_rdata);
        end
    endtask

    task automatic test_illegal_size();
        logic [3:0] sizes [4] = '{4'b0100, 4'b0000, 4'b0010, 4'b1111};
        foreach (sizes[i]) begin
            issue(1'b0, sizes[i], 64'h100, 64'h0, 0);
            drain("illegal");
            n_cmp++;
            if (rsp_rdata !== 64'h0) begin
                n_mis++;
                $display("FAIL illegal_rdata size=%b got %h want 0", sizes[i], rsp_rdata);
            end
        end
        hold_cfg = 0;
    endtask

    task automatic test_wrap();
        issue(1'b1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hA8A7A6A5A4A3A2A1, 0);
        drain("wrap_store");
        n_cmp++;
        if (mem_rd(64'h3) !== 8'hA8 || mem_rd(64'hFFFF_FFFF_FFFF_FFFC) !== 8'hA1) begin
            n_mis++;
            $display("FAIL wrap_mem got [3]=%h [..fc]=%h want a8 a1", mem_rd(64'h3), mem_rd(64'hFFFF_FFFF_FFFF_FFFC));
        end
        issue(1'b0, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2);
        drain("wrap_load");
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 4'b0001, 64'h300, 64'h0102030405060_7C3, 0);
        issue(1'b0, 4'b0001, 64'h300, 64'h0, 0);
        issue(1'b0, 4'b1000, 64'h20, 64'h0, 0);
        issue(1'b1, 4'b1000, 64'h308, 64'hCAFEF00D12345678, 0);
        issue(1'b0, 4'b1000, 64'h308, 64'h0, 0);
        drain("back_to_back");
    endtask

    task automatic test_reset_midop();
        issue(1'b0, 4'b1000, 64'h100, 64'h0, 0);
        repeat (4) step();
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_valid, stall, rsp_valid, req_ready} !== 4'b0001 || rsp_rdata !== 64'h0) begin
            n_mis++;
            $display("FAIL midop_reset got ctrl=%b rdata=%h want 0001 rdata=0",
                     {mem_valid, stall, rsp_valid, req_ready}, rsp_rdata);
        end
        exp_beat_q.delete();
        obs_beat_q.delete();
        exp_rsp_q.delete();
        obs_rsp_q.delete();
        step();
        step();
        reset_n = 1'b1;
        repeat (12) step();
        drain("post_reset_quiet");
        issue(1'b0, 4'b0001, 64'h103, 64'h0, 1);
        drain("post_reset_byte");
        n_cmp++;
        if (rsp_rdata !== 64'h04) begin
            n_mis++;
            $display("FAIL post_reset_rdata got %h want 4", rsp_rdata);
        end
    endtask

    task automatic test_random();
        logic [3:0] sizes [5] = '{4'd8, 4'd1, 4'd8, 4'd1, 4'd3};
        logic [63:0] base;
        for (int i = 0; i < 8; i++) begin
            base = {$urandom, $urandom};
            issue(1'($urandom), sizes[$urandom_range(0, 4)], base, {$urandom, $urandom}, $urandom_range(0, 2));
            drain("random");
            issue(1'b0, 4'd8, base, 64'h0, 0);
            drain("random_readback");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        mem_rdata = 8'h00;
        #1;
        test_reset();
        test_load8();
        test_store8();
        test_byte_wait();
        test_illegal_size();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
